// File: rtl/alu_pkg.sv
// Shared definitions for the integer ALU path: operation select encoding,
// major opcodes decoded by the front end, and the entry handed to execute.
package alu_pkg;

  localparam int unsigned ALU_XLEN    = 64;
  localparam int unsigned ALU_SHAMT_W = 6;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_SLL  = 4'd2,
    OP_SRL  = 4'd3,
    OP_SRA  = 4'd4,
    OP_OR   = 4'd5,
    OP_AND  = 4'd6,
    OP_XOR  = 4'd7,
    OP_SLTU = 4'd8,
    OP_SLT  = 4'd9
  } op_sel_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;
  localparam logic [5:0] FUNCT6_BASE = 6'b000000;
  localparam logic [5:0] FUNCT6_SRA  = 6'b010000;

  typedef struct packed {
    logic [ALU_XLEN-1:0] opr_a;
    logic [ALU_XLEN-1:0] opr_b;
    op_sel_e             op_sel;
    logic [4:0]          rd;
    logic                illegal;
  } ex_entry_t;

  localparam ex_entry_t ENTRY_RST = '{
    opr_a:   '0,
    opr_b:   '0,
    op_sel:  OP_ADD,
    rd:      '0,
    illegal: 1'b0
  };

  // funct3 -> operation for register and immediate forms; alt selects
  // SUB/SRA in the slots that have an alternate encoding.
  function automatic op_sel_e alu_op_from_f3(input logic [2:0] f3, input logic alt);
    op_sel_e op;
    case (f3)
      3'b000:  op = alt ? OP_SUB : OP_ADD;
      3'b001:  op = OP_SLL;
      3'b010:  op = OP_SLT;
      3'b011:  op = OP_SLTU;
      3'b100:  op = OP_XOR;
      3'b101:  op = alt ? OP_SRA : OP_SRL;
      3'b110:  op = OP_OR;
      default: op = OP_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_comb.sv
// Combinational decoder for OP / OP-IMM / LUI / AUIPC.
// Ports:
//   instr_i               instruction word
//   pc_i                  PC of instr_i
//   rs1_data_i/rs2_data_i register-file read data
//   entry_o               operands, ALU op, rd and illegal flag
// Unsupported encodings produce a zeroed ADD entry with illegal set and rd=0.
module decode_comb
  import alu_pkg::*;
#(
  parameter int unsigned XLEN    = ALU_XLEN,
  parameter int unsigned SHAMT_W = ALU_SHAMT_W
) (
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  output ex_entry_t       entry_o
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [5:0]      funct6;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] shamt;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];
  assign funct6 = instr_i[31:26];
  assign imm_i  = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
  assign imm_u  = {{(XLEN-32){instr_i[31]}}, instr_i[31:12], 12'b0};
  assign shamt  = {{(XLEN-SHAMT_W){1'b0}}, instr_i[20 +: SHAMT_W]};

  logic            legal;
  logic [XLEN-1:0] opr_a;
  logic [XLEN-1:0] opr_b;
  op_sel_e         op_sel;

  always_comb begin
    legal  = 1'b0;
    opr_a  = '0;
    opr_b  = '0;
    op_sel = OP_ADD;
    case (opcode)
      OPC_OP: begin
        if (funct7 == FUNCT7_BASE || funct7 == FUNCT7_ALT) begin
          legal  = 1'b1;
          opr_a  = rs1_data_i;
          opr_b  = rs2_data_i;
          op_sel = alu_op_from_f3(funct3, funct7[5]);
        end
      end
      OPC_OP_IMM: begin
        opr_a = rs1_data_i;
        if (funct3 == 3'b001) begin
          legal  = (funct6 == FUNCT6_BASE);
          opr_b  = shamt;
          op_sel = OP_SLL;
        end else if (funct3 == 3'b101) begin
          legal  = (funct6 == FUNCT6_BASE) || (funct6 == FUNCT6_SRA);
          opr_b  = shamt;
          op_sel = (funct6 == FUNCT6_SRA) ? OP_SRA : OP_SRL;
        end else begin
          legal  = 1'b1;
          opr_b  = imm_i;
          op_sel = alu_op_from_f3(funct3, 1'b0);
        end
      end
      OPC_LUI: begin
        legal = 1'b1;
        opr_b = imm_u;
      end
      OPC_AUIPC: begin
        legal = 1'b1;
        opr_a = pc_i;
        opr_b = imm_u;
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    entry_o = ENTRY_RST;
    if (legal) begin
      entry_o.opr_a  = opr_a;
      entry_o.opr_b  = opr_b;
      entry_o.op_sel = op_sel;
      entry_o.rd     = instr_i[11:7];
    end else begin
      entry_o.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/decode_issue.sv
// Decode/issue stage: decodes one instruction per cycle and hands ALU
// operands to execute through a registered valid/ready stage with a
// one-entry skid buffer, so instr_ready_o comes straight from a flop.
// Ports:
//   clk_i, reset_i             clock, synchronous active-high reset
//   flush_i                    discard all held entries, block acceptance
//   instr_valid_i/instr_ready_o  fetch handshake
//   instr_i, pc_i              instruction and its PC
//   rs1_addr_o/rs2_addr_o      register-file read addresses (combinational)
//   rs1_data_i/rs2_data_i      register-file read data (same cycle)
//   ex_valid_o/ex_ready_i      execute handshake
//   opr_a_o, opr_b_o, op_sel_o, rd_o, illegal_o  execute entry fields
module decode_issue
  import alu_pkg::*;
#(
  parameter int unsigned XLEN    = ALU_XLEN,
  parameter int unsigned SHAMT_W = ALU_SHAMT_W
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            flush_i,
  input  logic            instr_valid_i,
  output logic            instr_ready_o,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic [4:0]      rs1_addr_o,
  output logic [4:0]      rs2_addr_o,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  output logic            ex_valid_o,
  input  logic            ex_ready_i,
  output logic [XLEN-1:0] opr_a_o,
  output logic [XLEN-1:0] opr_b_o,
  output logic [3:0]      op_sel_o,
  output logic [4:0]      rd_o,
  output logic            illegal_o
);

  // Encoding is {out_valid, skid_valid} so both handshake outputs are
  // direct state-flop bits.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_OUT   = 2'b10,
    ST_FULL  = 2'b11
  } state_e;

  state_e    state_q, state_d;
  ex_entry_t out_q, out_d;
  ex_entry_t skid_q, skid_d;
  ex_entry_t dec_entry;
  logic      accept;
  logic      take;

  assign rs1_addr_o = instr_i[19:15];
  assign rs2_addr_o = instr_i[24:20];

  decode_comb #(
    .XLEN    (XLEN),
    .SHAMT_W (SHAMT_W)
  ) u_decode (
    .instr_i    (instr_i),
    .pc_i       (pc_i),
    .rs1_data_i (rs1_data_i),
    .rs2_data_i (rs2_data_i),
    .entry_o    (dec_entry)
  );

  // State and entry registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_EMPTY;
      out_q   <= ENTRY_RST;
      skid_q  <= ENTRY_RST;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

  // Next state and entry movement.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
      out_d   = ENTRY_RST;
      skid_d  = ENTRY_RST;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_OUT;
            out_d   = dec_entry;
          end
        end
        ST_OUT: begin
          if (accept && take) begin
            out_d = dec_entry;
          end else if (accept) begin
            state_d = ST_FULL;
            skid_d  = dec_entry;
          end else if (take) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (take) begin
            state_d = ST_OUT;
            out_d   = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Handshake and output fields.
  always_comb begin
    ex_valid_o    = state_q[1];
    instr_ready_o = ~state_q[0];
    accept        = instr_valid_i & instr_ready_o & ~flush_i;
    take          = ex_valid_o & ex_ready_i;
    opr_a_o       = out_q.opr_a;
    opr_b_o       = out_q.opr_b;
    op_sel_o      = out_q.op_sel;
    rd_o          = out_q.rd;
    illegal_o     = out_q.illegal;
  end

endmodule

// File: tb/tb_decode_issue.sv
module tb_decode_issue;
  import alu_pkg::*;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        flush_i;
  logic        instr_valid_i;
  logic        instr_ready_o;
  logic [31:0] instr_i;
  logic [63:0] pc_i;
  logic [4:0]  rs1_addr_o;
  logic [4:0]  rs2_addr_o;
  logic [63:0] rs1_data_i;
  logic [63:0] rs2_data_i;
  logic        ex_valid_o;
  logic        ex_ready_i;
  logic [63:0] opr_a_o;
  logic [63:0] opr_b_o;
  logic [3:0]  op_sel_o;
  logic [4:0]  rd_o;
  logic        illegal_o;

  decode_issue #(.XLEN(64), .SHAMT_W(6)) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .flush_i       (flush_i),
    .instr_valid_i (instr_valid_i),
    .instr_ready_o (instr_ready_o),
    .instr_i       (instr_i),
    .pc_i          (pc_i),
    .rs1_addr_o    (rs1_addr_o),
    .rs2_addr_o    (rs2_addr_o),
    .rs1_data_i    (rs1_data_i),
    .rs2_data_i    (rs2_data_i),
    .ex_valid_o    (ex_valid_o),
    .ex_ready_i    (ex_ready_i),
    .opr_a_o       (opr_a_o),
    .opr_b_o       (opr_b_o),
    .op_sel_o      (op_sel_o),
    .rd_o          (rd_o),
    .illegal_o     (illegal_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference decode straight from the ISA rules.
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [63:0] pc,
                                      input logic [63:0] r1, input logic [63:0] r2);
    exp_t        e;
    logic [3:0]  f3map [8];
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [5:0]  f6;
    longint      imm_i;
    longint      imm_u;
    bit          ok;
    f3map = '{OP_ADD, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_OR, OP_AND};
    opc   = ins[6:0];
    f3    = ins[14:12];
    f7    = ins[31:25];
    f6    = ins[31:26];
    imm_i = longint'($signed(ins[31:20]));
    imm_u = longint'($signed(ins[31:12])) * 4096;
    e     = '{64'd0, 64'd0, OP_ADD, 5'd0, 1'b0};
    ok    = 0;
    case (opc)
      7'h33: if (f7 == 7'h00 || f7 == 7'h20) begin
        ok = 1; e.a = r1; e.b = r2; e.op = f3map[f3];
        if (f7 == 7'h20 && f3 == 3'd0) e.op = OP_SUB;
        if (f7 == 7'h20 && f3 == 3'd5) e.op = OP_SRA;
      end
      7'h13: begin
        e.a = r1;
        if (f3 == 3'd1) begin
          ok = (f6 == 6'h00); e.b = 64'(ins[25:20]); e.op = OP_SLL;
        end else if (f3 == 3'd5) begin
          ok = (f6 == 6'h00) || (f6 == 6'h10); e.b = 64'(ins[25:20]);
          e.op = (f6 == 6'h10) ? OP_SRA : OP_SRL;
        end else begin
          ok = 1; e.b = imm_i; e.op = f3map[f3];
        end
      end
      7'h37: begin ok = 1; e.a = 64'd0; e.b = imm_u; e.op = OP_ADD; end
      7'h17: begin ok = 1; e.a = pc;    e.b = imm_u; e.op = OP_ADD; end
      default: ok = 0;
    endcase
    if (ok) e.rd = ins[11:7];
    else    e = '{64'd0, 64'd0, OP_ADD, 5'd0, 1'b1};
    return e;
  endfunction

  task automatic check_state(input string tag);
    check({tag, "_valid"}, 64'(ex_valid_o), 64'(q.size() != 0));
    check({tag, "_ready"}, 64'(instr_ready_o), 64'(q.size() < 2));
    if (q.size() != 0) begin
      check({tag, "_opr_a"},   opr_a_o,         q[0].a);
      check({tag, "_opr_b"},   opr_b_o,         q[0].b);
      check({tag, "_op_sel"},  64'(op_sel_o),   64'(q[0].op));
      check({tag, "_rd"},      64'(rd_o),       64'(q[0].rd));
      check({tag, "_illegal"}, 64'(illegal_o),  64'(q[0].ill));
    end
  endtask

  // One clock: drive, predict, clock, compare.
  task automatic step(input string tag, input logic v, input logic [31:0] ins,
                      input logic [63:0] pc, input logic [63:0] r1, input logic [63:0] r2,
                      input logic rdy, input logic fl);
    exp_t e;
    bit   tk, acc;
    instr_valid_i = v;
    instr_i       = ins;
    pc_i          = pc;
    rs1_data_i    = r1;
    rs2_data_i    = r2;
    ex_ready_i    = rdy;
    flush_i       = fl;
    #1;
    check({tag, "_rs1_addr"}, 64'(rs1_addr_o), 64'(ins[19:15]));
    check({tag, "_rs2_addr"}, 64'(rs2_addr_o), 64'(ins[24:20]));
    e   = ref_decode(ins, pc, r1, r2);
    tk  = (q.size() != 0) && rdy;
    acc = v && (q.size() < 2) && !fl;
    @(posedge clk_i); #1;
    if (fl) q.delete();
    else begin
      if (tk)  void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    check_state(tag);
  endtask

  task automatic do_reset(input string tag);
    reset_i = 1'b1;
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    q.delete();
    check({tag, "_valid"},   64'(ex_valid_o),    64'd0);
    check({tag, "_ready"},   64'(instr_ready_o), 64'd1);
    check({tag, "_opr_a"},   opr_a_o,            64'd0);
    check({tag, "_opr_b"},   opr_b_o,            64'd0);
    check({tag, "_op_sel"},  64'(op_sel_o),      64'(OP_ADD));
    check({tag, "_rd"},      64'(rd_o),          64'd0);
    check({tag, "_illegal"}, 64'(illegal_o),     64'd0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    int unsigned sel;
    ins = $urandom;
    sel = $urandom_range(0, 9);
    case (sel)
      0, 1, 2: begin
        ins[6:0] = 7'h33;
        case ($urandom_range(0, 3))
          0: ins[31:25] = 7'h00;
          1: ins[31:25] = 7'h20;
          2: ins[31:25] = 7'h01;
          default: ;
        endcase
      end
      3, 4, 5: begin
        ins[6:0] = 7'h13;
        case ($urandom_range(0, 2))
          0: ins[31:26] = 6'h00;
          1: ins[31:26] = 6'h10;
          default: ;
        endcase
      end
      6: ins[6:0] = 7'h37;
      7: ins[6:0] = 7'h17;
      8: ins[6:0] = 7'h3B;
      default: ;
    endcase
    return ins;
  endfunction

  initial begin
    reset_i = 1'b1; flush_i = 1'b0; instr_valid_i = 1'b0; instr_i = '0;
    pc_i = '0; rs1_data_i = '0; rs2_data_i = '0; ex_ready_i = 1'b0;
    @(posedge clk_i); #1;
    do_reset("reset");

    // ADDI x1,x2,-1
    step("addi", 1, 32'hFFF10093, 64'h1000, 64'h10, 64'h0, 1, 0);
    check("addi_rs1_const", 64'(rs1_addr_o), 64'd2);
    check("addi_a_const",   opr_a_o,         64'h10);
    check("addi_b_const",   opr_b_o,         64'hFFFF_FFFF_FFFF_FFFF);
    check("addi_op_const",  64'(op_sel_o),   64'(OP_ADD));
    check("addi_rd_const",  64'(rd_o),       64'd1);

    // SUB then SRAI back-to-back
    step("idle0", 0, 32'h0, 64'h0, 64'h0, 64'h0, 1, 0);
    step("sub",  1, 32'h402081B3, 64'h1004, 64'h55, 64'h22, 1, 0);
    check("sub_op_const",   64'(op_sel_o),   64'(OP_SUB));
    check("sub_rd_const",   64'(rd_o),       64'd3);
    step("srai", 1, 32'h43F0D093, 64'h1008, 64'h8000_0000_0000_0000, 64'h0, 1, 0);
    check("srai_valid_const", 64'(ex_valid_o), 64'd1);
    check("srai_op_const",    64'(op_sel_o),   64'(OP_SRA));
    check("srai_b_const",     opr_b_o,         64'd63);
    step("idle1", 0, 32'h0, 64'h0, 64'h0, 64'h0, 1, 0);

    // LUI / AUIPC
    step("lui", 1, 32'h123452B7, 64'h100C, 64'hDEAD, 64'hBEEF, 1, 0);
    check("lui_a_const", opr_a_o, 64'd0);
    check("lui_b_const", opr_b_o, 64'h0000_0000_1234_5000);
    step("auipc", 1, 32'h80000017, 64'h8000_0000, 64'h1, 64'h2, 1, 0);
    check("auipc_a_const",  opr_a_o,     64'h8000_0000);
    check("auipc_b_const",  opr_b_o,     64'hFFFF_FFFF_8000_0000);
    check("auipc_rd_const", 64'(rd_o),   64'd0);
    step("idle2", 0, 32'h0, 64'h0, 64'h0, 64'h0, 1, 0);

    // Backpressure: three offered, two held
    step("bp1", 1, 32'h00208033, 64'h0, 64'h11, 64'h22, 0, 0);
    step("bp2", 1, 32'h00310133, 64'h0, 64'h33, 64'h44, 0, 0);
    check("bp2_ready_const", 64'(instr_ready_o), 64'd0);
    step("bp3", 1, 32'h004181B3, 64'h0, 64'h55, 64'h66, 0, 0);
    check("bp3_a_stable", opr_a_o, 64'h11);
    step("drain1", 0, 32'h0, 64'h0, 64'h0, 64'h0, 1, 0);
    check("drain1_a_const", opr_a_o, 64'h33);
    step("drain2", 0, 32'h0, 64'h0, 64'h0, 64'h0, 1, 0);
    check("drain2_valid_const", 64'(ex_valid_o), 64'd0);

    // Flush while FULL with an instruction offered
    step("fl1", 1, 32'h00208033, 64'h0, 64'h1, 64'h2, 0, 0);
    step("fl2", 1, 32'h00208033, 64'h0, 64'h3, 64'h4, 0, 0);
    step("flush", 1, 32'h00208033, 64'h0, 64'h5, 64'h6, 1, 1);
    check("flush_valid_const", 64'(ex_valid_o),    64'd0);
    check("flush_ready_const", 64'(instr_ready_o), 64'd1);

    // MUL is illegal
    step("mul", 1, 32'h023100B3, 64'h0, 64'h77, 64'h88, 1, 0);
    check("mul_ill_const", 64'(illegal_o), 64'd1);
    check("mul_op_const",  64'(op_sel_o),  64'(OP_ADD));
    check("mul_a_const",   opr_a_o,        64'd0);
    check("mul_b_const",   opr_b_o,        64'd0);
    check("mul_rd_const",  64'(rd_o),      64'd0);

    // Reset while stalled in FULL
    step("rs1", 1, 32'h00208033, 64'h0, 64'h9, 64'hA, 0, 0);
    step("rs2", 1, 32'h00208033, 64'h0, 64'hB, 64'hC, 0, 0);
    do_reset("midreset");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step("rnd", 1'($urandom_range(0, 3) != 0), rand_instr(), {$urandom, $urandom},
           {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 24) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
